// File: rtl/matrix_skew_feeder.sv
// -----------------------------------------------------------------------------
// matrix_skew_feeder
//
// Operand feeder for a DIM x DIM systolic array. A tile of signed elements is
// written by (row, col) address while idle. A start pulse then streams the
// tile into DIM lanes with a diagonal skew: lane i runs i cycles behind lane 0,
// so the data arrives in step with the array's wavefront. Streaming is either
// row-major (lane i walks row i) or transposed (lane i walks column i). The
// stream can be stalled with en=0.
//
// Optional build macro: MATRIX_FEEDER_DBUF_EN
//   Defined   : two tile banks. Writes always go to the back bank, in any
//               state. An accepted start swaps the banks, so a write in the
//               start cycle lands in the bank that is about to be streamed.
//   Undefined : one bank; writes are accepted only while idle.
//
// Parameters
//   DIM   tile dimension and lane count (>= 2)
//   BITS  signed element width
//
// Ports
//   clk        clock
//   rst        synchronous active-high reset (aborts a stream, no done pulse)
//   wr_en      write strobe
//   wr_row     write row address
//   wr_col     write column address
//   wr_data    write data (signed)
//   start      begin streaming the tile (ignored unless idle)
//   transpose  sampled with start: 0 = row-major, 1 = transposed
//   en         stream advance enable (0 = stall, outputs hold)
//   busy       high while streaming
//   done       one-cycle pulse after the last stream cycle
//   q          lane outputs, lane i in q[i]
//   q_valid    per-lane valid, lane i in bit i
// -----------------------------------------------------------------------------
module matrix_skew_feeder #(
  parameter int DIM  = 8,
  parameter int BITS = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            wr_en,
  input  logic [$clog2(DIM)-1:0]          wr_row,
  input  logic [$clog2(DIM)-1:0]          wr_col,
  input  logic signed [BITS-1:0]          wr_data,
  input  logic                            start,
  input  logic                            transpose,
  input  logic                            en,
  output logic                            busy,
  output logic                            done,
  output logic signed [DIM-1:0][BITS-1:0] q,
  output logic [DIM-1:0]                  q_valid
);

  localparam int AW = $clog2(DIM);
  // Step counter runs 0 .. 2*DIM-2, so it needs room for 2*DIM-1 values.
  localparam int CW = $clog2(2 * DIM);
  localparam logic [CW-1:0] C_LAST = CW'(2 * DIM - 2);
  localparam logic [CW-1:0] C_DIM  = CW'(DIM);
  // One extra bit so the range check also works when DIM is a power of two.
  localparam logic [AW:0]   A_DIM  = (AW + 1)'(DIM);

`ifdef MATRIX_FEEDER_DBUF_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [CW-1:0]          r_c;
  logic [CW-1:0]          w_c_next;
  logic                   r_transpose;
  logic                   w_start_accept;
  logic                   w_addr_ok;
  logic                   w_wr_accept;
  logic                   w_wr_bank;
  logic                   w_rd_bank;

  logic signed [BITS-1:0] r_tile [NB][DIM][DIM];

  // ---------------------------------------------------------------------------
  // Write path / bank selection
  // ---------------------------------------------------------------------------
  assign w_start_accept = (r_state == S_IDLE) && start;

  // Only matters for non power-of-two DIM; otherwise always true.
  assign w_addr_ok = ({1'b0, wr_row} < A_DIM) && ({1'b0, wr_col} < A_DIM);

`ifdef MATRIX_FEEDER_DBUF_EN
  logic r_bank_act;

  // The back bank is always the inactive one. Because the swap happens on the
  // same edge as a start-cycle write, that write ends up in the new active bank.
  assign w_wr_accept = wr_en && w_addr_ok;
  assign w_wr_bank   = ~r_bank_act;
  assign w_rd_bank   = r_bank_act;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank_act <= 1'b0;
    end else if (w_start_accept) begin
      r_bank_act <= ~r_bank_act;
    end
  end
`else
  // The tile must stay frozen while it is being streamed.
  assign w_wr_accept = wr_en && w_addr_ok && (r_state == S_IDLE);
  assign w_wr_bank   = 1'b0;
  assign w_rd_bank   = 1'b0;
`endif

  // Every lane reads a different element each cycle, so the tile lives in
  // registers rather than a single-port memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < NB; b++) begin
        for (int r = 0; r < DIM; r++) begin
          for (int c = 0; c < DIM; c++) begin
            r_tile[b][r][c] <= '0;
          end
        end
      end
    end else if (w_wr_accept) begin
      r_tile[w_wr_bank][wr_row][wr_col] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_c         <= '0;
      r_transpose <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_c     <= w_c_next;
      if (w_start_accept) begin
        r_transpose <= transpose;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_c_next     = r_c;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_next = S_STREAM;
          w_c_next     = '0;
        end
      end
      S_STREAM: begin
        busy = 1'b1;
        // A stall freezes the counter; lane outputs are a pure function of the
        // counter and the (unchanging) active tile, so they hold as well.
        if (en) begin
          if (r_c == C_LAST) begin
            w_state_next = S_DONE;
            w_c_next     = '0;
          end else begin
            w_c_next = r_c + CW'(1);
          end
        end
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Skewed lanes: lane gi shows element e = c - gi when 0 <= e < DIM.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
    logic [CW-1:0]          w_e;
    logic                   w_in_window;
    logic [AW-1:0]          w_idx;
    logic signed [BITS-1:0] w_row_major;
    logic signed [BITS-1:0] w_transposed;

    // w_e wraps when c < gi; the c >= gi term rejects those cycles.
    assign w_e         = r_c - CW'(gi);
    assign w_in_window = (r_c >= CW'(gi)) && (w_e < C_DIM);
    assign w_idx       = w_e[AW-1:0];

    assign w_row_major  = r_tile[w_rd_bank][gi][w_idx];
    assign w_transposed = r_tile[w_rd_bank][w_idx][gi];

    assign q_valid[gi] = (r_state == S_STREAM) && w_in_window;
    assign q[gi]       = q_valid[gi] ? (r_transpose ? w_transposed : w_row_major)
                                     : '0;
  end

endmodule
